conv1d_out_packer: RTL and testbench

- Output stage directly downstream of the conv1d CFU.
- Takes each quantized, activation-clamped result as it completes and saturates it to int8.
- Packs four results little-endian into one 32-bit word and queues the words in a small FIFO for the CPU to drain one per instruction.
- Replaces the one-result-per-readback path, so the CPU issues a single read per four outputs.

---
 rtl/conv1d_pkg.sv | 22 ++
 rtl/word_fifo.sv | 58 +++++
 rtl/conv1d_out_packer.sv | 100 ++++++++++
 tb/tb_conv1d_out_packer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared constants for the conv1d CFU and its output packer.
package conv1d_pkg;

    localparam int BYTE_SIZE  = 8;
    localparam int INT32_SIZE = 32;

    localparam int signed INT8_MIN = -128;
    localparam int signed INT8_MAX = 127;

    // CFU command codes decoded by the conv1d instruction front end.
    typedef enum logic [3:0] {
        CMD_RESET       = 4'd0,
        CMD_LOAD_COEF   = 4'd1,
        CMD_LOAD_DATA   = 4'd2,
        CMD_RUN         = 4'd3,
        CMD_READ_RESULT = 4'd4,
        CMD_POP         = 4'd5,
        CMD_FLUSH       = 4'd6,
        CMD_STATUS      = 4'd7
    } cfu_cmd_e;

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through word FIFO; head reads 0 while empty.
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);
    import conv1d_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [PW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (PW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_q];
    assign level   = level_q;

    // Storage write; contents need no reset because head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/conv1d_out_packer.sv
// Saturates conv1d results to int8, packs four per word little-endian, queues words for the CPU.
module conv1d_out_packer #(
    parameter int BYTE_SIZE  = 8,
    parameter int INT32_SIZE = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic signed [INT32_SIZE-1:0]  in_data,
    output logic                          in_ready,
    input  logic                          flush,
    input  logic                          pop,
    output logic [INT32_SIZE-1:0]         out_word,
    output logic                          out_valid,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [1:0]                    byte_cnt,
    output logic                          overflow
);
    import conv1d_pkg::*;

    function automatic logic [BYTE_SIZE-1:0] sat_int8(input logic signed [INT32_SIZE-1:0] v);
        logic [BYTE_SIZE-1:0] r;
        if (v < INT8_MIN)      r = INT8_MIN[BYTE_SIZE-1:0];
        else if (v > INT8_MAX) r = INT8_MAX[BYTE_SIZE-1:0];
        else                   r = v[BYTE_SIZE-1:0];
        return r;
    endfunction

    logic [INT32_SIZE-1:0] pack_q, pack_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [INT32_SIZE-1:0] merged;
    logic                  accept, drop, push, fifo_pop, full, empty;

    // Accept/drop decision, lane merge, and word completion or flush.
    always_comb begin
        accept     = en && in_valid && in_ready;
        drop       = en && in_valid && !in_ready;
        merged     = pack_q;
        if (accept) merged[byte_cnt_q*BYTE_SIZE +: BYTE_SIZE] = sat_int8(in_data);
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        push       = 1'b0;
        overflow_d = overflow_q | drop;
        if (accept) begin
            if (byte_cnt_q == 2'd3 || (en && flush)) begin
                // A completing byte already pushes the word, so a simultaneous flush adds nothing.
                push       = 1'b1;
                pack_d     = '0;
                byte_cnt_d = 2'd0;
            end else begin
                pack_d     = merged;
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end else if (en && flush && !in_valid && in_ready && byte_cnt_q != 2'd0) begin
            // Unfilled lanes are already zero because the pack register clears on every push.
            push       = 1'b1;
            pack_d     = '0;
            byte_cnt_d = 2'd0;
        end
    end

    // Pack register, lane counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q     <= '0;
            byte_cnt_q <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign fifo_pop = en && pop && !empty;

    word_fifo #(
        .WIDTH (INT32_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (merged),
        .pop       (fifo_pop),
        .full      (full),
        .empty     (empty),
        .head      (out_word),
        .level     (level)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign byte_cnt  = byte_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv1d_out_packer.sv
// Directed bench for conv1d_out_packer with hand-computed expectations.
module tb_conv1d_out_packer;

    logic               clk = 1'b0;
    logic               rst, en, in_valid, flush, pop;
    logic signed [31:0] in_data;
    logic               in_ready, out_valid, overflow;
    logic [31:0]        out_word;
    logic [4:0]         level;
    logic [1:0]         byte_cnt;
    int                 passed = 0;
    int                 total  = 0;

    always #5 clk = ~clk;

    conv1d_out_packer #(
        .BYTE_SIZE  (8),
        .INT32_SIZE (32),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .pop       (pop),
        .out_word  (out_word),
        .out_valid (out_valid),
        .level     (level),
        .byte_cnt  (byte_cnt),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input logic fl = 1'b0, input logic pp = 1'b0);
        in_valid = 1'b1;
        in_data  = v;
        flush    = fl;
        pop      = pp;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; flush = 1'b0; pop = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_overflow", overflow, 0);

        // Saturating pack of four results
        feed(1);
        chk("t1_cnt1", byte_cnt, 1);
        chk("t1_no_word_yet", out_valid, 0);
        feed(-2); feed(300); feed(-500);
        chk("t1_word", out_word, 32'h807F_FE01);
        chk("t1_level", level, 1);
        chk("t1_cnt0", byte_cnt, 0);
        chk("t1_valid", out_valid, 1);
        do_pop();
        chk("t1_pop_level", level, 0);

        // Partial word via flush, then a redundant flush
        feed(5); feed(6);
        chk("t2_cnt2", byte_cnt, 2);
        do_flush();
        chk("t2_word", out_word, 32'h0000_0605);
        chk("t2_level", level, 1);
        chk("t2_cnt0", byte_cnt, 0);
        do_flush();
        chk("t2_flush_noop_level", level, 1);
        do_pop();

        // Pop while empty
        do_pop();
        chk("t3_empty_level", level, 0);
        chk("t3_empty_word", out_word, 0);
        chk("t3_empty_valid", out_valid, 0);

        // Three words queued, then completing byte with pop in the same cycle
        for (int i = 1; i <= 12; i++) feed(i);
        chk("t4_level3", level, 3);
        chk("t4_head0", out_word, 32'h0403_0201);
        feed(13); feed(14); feed(15);
        feed(16, 1'b0, 1'b1);
        chk("t4_pushpop_level", level, 3);
        chk("t4_head1", out_word, 32'h0807_0605);
        do_pop();
        chk("t4_head2", out_word, 32'h0C0B_0A09);
        do_pop();
        chk("t4_head3", out_word, 32'h100F_0E0D);
        do_pop();
        chk("t4_drained", level, 0);

        // Completing byte with flush pushes once; byte plus flush on a partial pushes it
        feed(8'h21); feed(8'h22); feed(8'h23);
        feed(8'h24, 1'b1);
        chk("t5_one_word", level, 1);
        chk("t5_word", out_word, 32'h2423_2221);
        chk("t5_cnt0", byte_cnt, 0);
        feed(8'h31, 1'b1);
        chk("t5_partial_flush_level", level, 2);
        chk("t5_partial_flush_cnt", byte_cnt, 0);
        do_pop();
        chk("t5_partial_word", out_word, 32'h0000_0031);

        // Reset mid-operation with 5 words queued and 2 bytes pending
        for (int i = 0; i < 16; i++) feed(i + 64);
        feed(7); feed(9);
        chk("t6_level5", level, 5);
        chk("t6_cnt2", byte_cnt, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_cnt", byte_cnt, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_word", out_word, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_overflow", overflow, 0);
        feed(8'h55);
        do_flush();
        chk("t6_pack_cleared", out_word, 32'h0000_0055);

        // en low freezes everything
        feed(3);
        en = 1'b0; in_valid = 1'b1; in_data = 99; flush = 1'b1; pop = 1'b1;
        step(); step();
        in_valid = 1'b0; flush = 1'b0; pop = 1'b0; en = 1'b1;
        chk("t7_level", level, 1);
        chk("t7_cnt", byte_cnt, 1);
        chk("t7_word", out_word, 32'h0000_0055);
        do_pop();
        do_flush();
        do_pop();
        chk("t7_cleanup", level, 0);

        // Fill to full, drop on overflow, push while full with pop
        for (int w = 1; w <= 16; w++)
            for (int b = 0; b < 4; b++) feed(w);
        chk("t8_full_level", level, 16);
        chk("t8_in_ready", in_ready, 0);
        chk("t8_no_ovf_yet", overflow, 0);
        feed(77);
        chk("t8_overflow", overflow, 1);
        chk("t8_drop_cnt", byte_cnt, 0);
        chk("t8_drop_level", level, 16);
        feed(78, 1'b1, 1'b1);
        chk("t8_pushpop_full_level", level, 15);
        chk("t8_pushpop_full_cnt", byte_cnt, 0);
        chk("t8_head", out_word, 32'h0202_0202);
        for (int i = 0; i < 15; i++) do_pop();
        chk("t8_drained", level, 0);
        chk("t8_ovf_sticky", overflow, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
